// File: rtl/reg_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_arbiter_if
//  Description : Bundle of the host and loader req/ack ports plus the
//                register bus driven by reg_bus_arbiter.
//                master : the arbiter side (owns the register bus, issues acks)
//                slave  : the environment side (requesters and Registers block)
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    // Host MCU requester
    logic                  host_req;
    logic                  host_wr;
    logic [1:0]            host_be;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_rdata;

    // Vblank register loader requester
    logic                  ldr_req;
    logic                  ldr_wr;
    logic [1:0]            ldr_be;
    logic [ADDR_WIDTH-1:0] ldr_addr;
    logic [DATA_WIDTH-1:0] ldr_wdata;
    logic                  ldr_ack;
    logic [DATA_WIDTH-1:0] ldr_rdata;

    // Register bus
    logic                  reg_en;
    logic                  reg_rd;
    logic                  reg_wr;
    logic [1:0]            reg_be;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;

    modport master (
        input  host_req, host_wr, host_be, host_addr, host_wdata,
        output host_ack, host_rdata,
        input  ldr_req, ldr_wr, ldr_be, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata,
        output reg_en, reg_rd, reg_wr, reg_be, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        output host_req, host_wr, host_be, host_addr, host_wdata,
        input  host_ack, host_rdata,
        output ldr_req, ldr_wr, ldr_be, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata,
        input  reg_en, reg_rd, reg_wr, reg_be, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_arbiter
//  Description : Arbitrates the Registers block between the host MCU bus and
//                the vblank register loader, and sequences a fixed
//                SETUP / STROBE / HOLD cycle per access. reg_wr never changes
//                in the same cycle as address, data or reg_en, so the
//                register's falling-edge latch always sees a stable bus.
//                Optional macro REG_ARB_ROUND_ROBIN_EN selects round-robin
//                tie-breaking; otherwise the host has fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input wire              clk,
    input wire              reset,
    reg_bus_arbiter_if.master bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_strobe = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_grant_ldr;   // 1: loader owns the access in flight
    logic                  r_wr_op;       // 1: access in flight is a write

    logic                  r_reg_en;
    logic                  r_reg_rd;
    logic                  r_reg_wr;
    logic [1:0]            r_reg_be;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [DATA_WIDTH-1:0] r_reg_wdata;

    logic                  r_host_ack;
    logic                  r_ldr_ack;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;

    logic                  w_host_elig;
    logic                  w_ldr_elig;
    logic                  w_pick_ldr;
    logic                  w_grant;
    logic                  w_sel_wr;
    logic [1:0]            w_sel_be;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // A requester being acked this cycle is still holding req from the
    // finished access, so it must not be re-granted until the next cycle.
    assign w_host_elig = bus.host_req & ~r_host_ack;
    assign w_ldr_elig  = bus.ldr_req  & ~r_ldr_ack;

`ifdef REG_ARB_ROUND_ROBIN_EN
    // Set when the loader was granted last; reset so the loader wins the first tie.
    logic r_last_ldr;

    assign w_pick_ldr = w_ldr_elig & (~w_host_elig | ~r_last_ldr);
`else
    // Host wins every tie; the loader only gets the bus when the host is quiet.
    assign w_pick_ldr = w_ldr_elig & ~w_host_elig;
`endif

    assign w_grant = (r_state == c_st_idle) & (w_host_elig | w_ldr_elig);

    // Request fields of the winner, sampled only at grant.
    assign w_sel_wr    = w_pick_ldr ? bus.ldr_wr    : bus.host_wr;
    assign w_sel_be    = w_pick_ldr ? bus.ldr_be    : bus.host_be;
    assign w_sel_addr  = w_pick_ldr ? bus.ldr_addr  : bus.host_addr;
    assign w_sel_wdata = w_pick_ldr ? bus.ldr_wdata : bus.host_wdata;

    // Access sequencer: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   if (w_grant) r_state <= c_st_setup;
                c_st_setup:  r_state <= c_st_strobe;
                c_st_strobe: r_state <= c_st_hold;
                c_st_hold:   r_state <= c_st_idle;
                default:     r_state <= c_st_idle;
            endcase
        end
    end

    // Remember who was granted and what kind of access it is.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_ldr <= 1'b0;
            r_wr_op     <= 1'b0;
        end else if (w_grant) begin
            r_grant_ldr <= w_pick_ldr;
            r_wr_op     <= w_sel_wr;
        end
    end

    // Address, data and byte enables are loaded at grant and then held
    // untouched until the next grant, which keeps them stable around reg_wr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_be    <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
        end else if (w_grant) begin
            r_reg_be    <= w_sel_be;
            r_reg_addr  <= w_sel_addr;
            r_reg_wdata <= w_sel_wdata;
        end
    end

    // Bus strobes: en spans SETUP..HOLD, rd spans SETUP..STROBE for reads,
    // wr is high only in STROBE for writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_en <= 1'b0;
            r_reg_rd <= 1'b0;
            r_reg_wr <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_reg_en <= 1'b1;
                        r_reg_rd <= ~w_sel_wr;
                        r_reg_wr <= 1'b0;
                    end
                end
                c_st_setup: begin
                    r_reg_wr <= r_wr_op;
                end
                c_st_strobe: begin
                    r_reg_rd <= 1'b0;
                    r_reg_wr <= 1'b0;
                end
                c_st_hold: begin
                    r_reg_en <= 1'b0;
                end
                default: begin
                    r_reg_en <= 1'b0;
                    r_reg_rd <= 1'b0;
                    r_reg_wr <= 1'b0;
                end
            endcase
        end
    end

    // Read data is captured at the end of STROBE into the granted port only;
    // writes and the other port's accesses leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_rdata <= '0;
            r_ldr_rdata  <= '0;
        end else if ((r_state == c_st_strobe) && !r_wr_op) begin
            if (r_grant_ldr) begin
                r_ldr_rdata  <= bus.reg_rdata;
            end else begin
                r_host_rdata <= bus.reg_rdata;
            end
        end
    end

    // One-cycle completion pulse to the granted port as HOLD is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_ack <= 1'b0;
            r_ldr_ack  <= 1'b0;
        end else begin
            r_host_ack <= (r_state == c_st_hold) & ~r_grant_ldr;
            r_ldr_ack  <= (r_state == c_st_hold) &  r_grant_ldr;
        end
    end

`ifdef REG_ARB_ROUND_ROBIN_EN
    // Round-robin pointer follows every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ldr <= 1'b0;
        end else if (w_grant) begin
            r_last_ldr <= w_pick_ldr;
        end
    end
`endif

    assign bus.reg_en     = r_reg_en;
    assign bus.reg_rd     = r_reg_rd;
    assign bus.reg_wr     = r_reg_wr;
    assign bus.reg_be     = r_reg_be;
    assign bus.reg_addr   = r_reg_addr;
    assign bus.reg_wdata  = r_reg_wdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.host_rdata = r_host_rdata;
    assign bus.ldr_ack    = r_ldr_ack;
    assign bus.ldr_rdata  = r_ldr_rdata;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bus_arbiter
//  Description : Scoreboard bench for reg_bus_arbiter. Stimulus pushes the
//                expected bus beats and acks; a monitor compares them against
//                the DUT on the falling clock edge. A small register-file
//                model answers reads and commits writes on the falling edge
//                of reg_wr. Honours REG_ARB_ROUND_ROBIN_EN for grant order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bus_arbiter;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [15:0] rdata;
    } ack_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    beat_t bus_q[$];
    ack_t  host_q[$];
    ack_t  ldr_q[$];

    logic [15:0] mem [256];
    logic        wr_q;

    reg_bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    reg_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected acks.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Registers block model: combinational read, commit on falling edge of reg_wr.
    assign bus.reg_rdata = mem[bus.reg_addr[7:0]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            wr_q <= 1'b0;
        end else begin
            if (wr_q && !bus.reg_wr) begin
                if (bus.reg_be[0]) mem[bus.reg_addr[7:0]][7:0]  <= bus.reg_wdata[7:0];
                if (bus.reg_be[1]) mem[bus.reg_addr[7:0]][15:8] <= bus.reg_wdata[15:8];
            end
            wr_q <= bus.reg_wr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_beats(input logic wr, input logic [1:0] be,
                              input logic [15:0] addr, input logic [15:0] wd, input int n);
        beat_t b;
        b.be = be; b.addr = addr; b.wdata = wd;
        b.rd = ~wr; b.wr = 1'b0;       bus_q.push_back(b);   // SETUP
        if (n > 1) begin
            b.rd = ~wr; b.wr = wr;     bus_q.push_back(b);   // STROBE
        end
        if (n > 2) begin
            b.rd = 1'b0; b.wr = 1'b0;  bus_q.push_back(b);   // HOLD
        end
    endtask

    task automatic push_ack(input bit ldr, input int c, input logic [15:0] rd);
        ack_t a;
        a.cyc = c; a.rdata = rd;
        if (ldr) ldr_q.push_back(a); else host_q.push_back(a);
    endtask

    // Issue one access and wait (bounded) for its ack; req drops in the ack cycle.
    task automatic drive(input bit ldr, input logic wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wd);
        bit seen;
        seen = 1'b0;
        if (ldr) begin
            bus.ldr_req = 1'b1; bus.ldr_wr = wr; bus.ldr_be = be;
            bus.ldr_addr = addr; bus.ldr_wdata = wd;
        end else begin
            bus.host_req = 1'b1; bus.host_wr = wr; bus.host_be = be;
            bus.host_addr = addr; bus.host_wdata = wd;
        end
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #1;
            seen = ldr ? bus.ldr_ack : bus.host_ack;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ack_timeout: port %0d got no ack, required ack within 40 cycles", ldr);
        end
        if (ldr) bus.ldr_req = 1'b0; else bus.host_req = 1'b0;
    endtask

    task automatic monitor();
        beat_t b;
        ack_t  a;
        forever begin
            @(negedge clk);
            if (bus.reg_en === 1'b1) begin
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat_unexpected: got reg_en=1 addr %h, required reg_en=0 (cycle %0d)",
                             bus.reg_addr, cyc);
                end else begin
                    b = bus_q.pop_front();
                    check("beat_rd",    32'(bus.reg_rd),    32'(b.rd));
                    check("beat_wr",    32'(bus.reg_wr),    32'(b.wr));
                    check("beat_be",    32'(bus.reg_be),    32'(b.be));
                    check("beat_addr",  32'(bus.reg_addr),  32'(b.addr));
                    check("beat_wdata", 32'(bus.reg_wdata), 32'(b.wdata));
                end
            end else begin
                check("idle_strobes", 32'({bus.reg_rd, bus.reg_wr}), 32'(2'b00));
            end
            if (bus.host_ack === 1'b1) begin
                if (host_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL host_ack_unexpected: got host_ack=1, required 0 (cycle %0d)", cyc);
                end else begin
                    a = host_q.pop_front();
                    check("host_ack_cycle", 32'(cyc), 32'(a.cyc));
                    check("host_rdata",     32'(bus.host_rdata), 32'(a.rdata));
                end
            end
            if (bus.ldr_ack === 1'b1) begin
                if (ldr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ldr_ack_unexpected: got ldr_ack=1, required 0 (cycle %0d)", cyc);
                end else begin
                    a = ldr_q.pop_front();
                    check("ldr_ack_cycle", 32'(cyc), 32'(a.cyc));
                    check("ldr_rdata",     32'(bus.ldr_rdata), 32'(a.rdata));
                end
            end
        end
    endtask

    task automatic check_reg_idle(input string tag);
        check({tag, "_reg_en"},     32'(bus.reg_en),     32'd0);
        check({tag, "_reg_rd"},     32'(bus.reg_rd),     32'd0);
        check({tag, "_reg_wr"},     32'(bus.reg_wr),     32'd0);
        check({tag, "_reg_be"},     32'(bus.reg_be),     32'd0);
        check({tag, "_reg_addr"},   32'(bus.reg_addr),   32'd0);
        check({tag, "_reg_wdata"},  32'(bus.reg_wdata),  32'd0);
        check({tag, "_host_ack"},   32'(bus.host_ack),   32'd0);
        check({tag, "_ldr_ack"},    32'(bus.ldr_ack),    32'd0);
        check({tag, "_host_rdata"}, 32'(bus.host_rdata), 32'd0);
        check({tag, "_ldr_rdata"},  32'(bus.ldr_rdata),  32'd0);
    endtask

    initial begin
        int c0;
        total = 0; bad = 0;
        reset = 1'b1;
        bus.host_req = 0; bus.host_wr = 0; bus.host_be = 0; bus.host_addr = 0; bus.host_wdata = 0;
        bus.ldr_req  = 0; bus.ldr_wr  = 0; bus.ldr_be  = 0; bus.ldr_addr  = 0; bus.ldr_wdata  = 0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reg_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Host write 0x0010 <= 0xBEEF, full word.
        c0 = cyc;
        push_beats(1'b1, 2'b11, 16'h0010, 16'hBEEF, 3);
        push_ack(1'b0, c0 + 4, 16'h0000);
        drive(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF);

        // Host read back 0x0010.
        @(posedge clk); #1; c0 = cyc;
        push_beats(1'b0, 2'b11, 16'h0010, 16'h0000, 3);
        push_ack(1'b0, c0 + 4, 16'hBEEF);
        drive(1'b0, 1'b0, 2'b11, 16'h0010, 16'h0000);

        // Host write 0x0012 <= 0x1234; host_rdata keeps 0xBEEF.
        @(posedge clk); #1; c0 = cyc;
        push_beats(1'b1, 2'b11, 16'h0012, 16'h1234, 3);
        push_ack(1'b0, c0 + 4, 16'hBEEF);
        drive(1'b0, 1'b1, 2'b11, 16'h0012, 16'h1234);

        // Loader read 0x0012 returns 0x1234; host_rdata untouched.
        @(posedge clk); #1; c0 = cyc;
        push_beats(1'b0, 2'b11, 16'h0012, 16'h0000, 3);
        push_ack(1'b1, c0 + 4, 16'h1234);
        drive(1'b1, 1'b0, 2'b11, 16'h0012, 16'h0000);
        check("host_rdata_after_ldr_read", 32'(bus.host_rdata), 32'h0000BEEF);

        // Low-byte write 0xAA55 to 0x0010, then read back 0xBE55.
        @(posedge clk); #1; c0 = cyc;
        push_beats(1'b1, 2'b01, 16'h0010, 16'hAA55, 3);
        push_ack(1'b0, c0 + 4, 16'hBEEF);
        drive(1'b0, 1'b1, 2'b01, 16'h0010, 16'hAA55);
        @(posedge clk); #1; c0 = cyc;
        push_beats(1'b0, 2'b11, 16'h0010, 16'h0000, 3);
        push_ack(1'b0, c0 + 4, 16'hBE55);
        drive(1'b0, 1'b0, 2'b11, 16'h0010, 16'h0000);

        // Address changed in C2 must not disturb the latched address.
        @(posedge clk); #1; c0 = cyc;
        push_beats(1'b0, 2'b11, 16'h0012, 16'h0000, 3);
        push_ack(1'b0, c0 + 4, 16'h1234);
        fork
            drive(1'b0, 1'b0, 2'b11, 16'h0012, 16'h0000);
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.host_addr = 16'h0010;
            end
        join

        // Reset asserted during STROBE of a write: no ack, bus back to reset values.
        @(posedge clk); #1;
        push_beats(1'b1, 2'b11, 16'h0040, 16'h5555, 2);
        bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_be = 2'b11;
        bus.host_addr = 16'h0040; bus.host_wdata = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.host_req = 1'b0;
        @(posedge clk); #1;
        check_reg_idle("midreset");
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_beats_left", 32'(bus_q.size()),  32'd0);
        check("midreset_host_acks",  32'(host_q.size()), 32'd0);

        // Both requesters from reset, each issuing two accesses back to back.
        @(posedge clk); #1; c0 = cyc;
`ifdef REG_ARB_ROUND_ROBIN_EN
        push_beats(1'b1, 2'b11, 16'h0020, 16'h1111, 3);   // loader write
        push_beats(1'b1, 2'b11, 16'h0030, 16'h2222, 3);   // host write
        push_beats(1'b0, 2'b11, 16'h0030, 16'h0000, 3);   // loader read
        push_beats(1'b0, 2'b11, 16'h0020, 16'h0000, 3);   // host read
        push_ack(1'b1, c0 + 4,  16'h0000);
        push_ack(1'b0, c0 + 8,  16'h0000);
        push_ack(1'b1, c0 + 12, 16'h2222);
        push_ack(1'b0, c0 + 16, 16'h1111);
`else
        push_beats(1'b1, 2'b11, 16'h0030, 16'h2222, 3);   // host write
        push_beats(1'b1, 2'b11, 16'h0020, 16'h1111, 3);   // loader write
        push_beats(1'b0, 2'b11, 16'h0020, 16'h0000, 3);   // host read
        push_beats(1'b0, 2'b11, 16'h0030, 16'h0000, 3);   // loader read
        push_ack(1'b0, c0 + 4,  16'h0000);
        push_ack(1'b1, c0 + 8,  16'h0000);
        push_ack(1'b0, c0 + 12, 16'h1111);
        push_ack(1'b1, c0 + 16, 16'h2222);
`endif
        fork
            begin
                drive(1'b0, 1'b1, 2'b11, 16'h0030, 16'h2222);
                drive(1'b0, 1'b0, 2'b11, 16'h0020, 16'h0000);
            end
            begin
                drive(1'b1, 1'b1, 2'b11, 16'h0020, 16'h1111);
                drive(1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000);
            end
        join

        repeat (4) @(posedge clk);
        #1;
        check("final_beats_left", 32'(bus_q.size()),  32'd0);
        check("final_host_acks",  32'(host_q.size()), 32'd0);
        check("final_ldr_acks",   32'(ldr_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Sequences and arbitrates access to the `Registers` block between two requesters: the host MCU bus interface (port `host_`) and the internal vblank register loader (port `ldr_`). It owns the register bus (`en`/`rd`/`wr`/`be`/`addr`/`data_in`) and generates a fixed three-phase read or write cycle from a synchronous req/ack handshake. Register writes latch on the falling edge of `wr`, so the arbiter never lets `wr` change in the same cycle as address, data or `en`.

## Interface
- `ADDR_WIDTH`, default 16: register address width.
- `DATA_WIDTH`, default 16: register data width.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `host_req`  in  1  host access request; held high until `host_ack`.
- `host_wr`  in  1  1 = write, 0 = read.
- `host_be`  in  2  byte enables.
- `host_addr`  in  ADDR_WIDTH  register address.
- `host_wdata`  in  DATA_WIDTH  write data.
- `host_ack`  out  1  one-cycle completion pulse.
- `host_rdata`  out  DATA_WIDTH  read data; valid while `host_ack` is high.
- `ldr_req`, `ldr_wr`, `ldr_be`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: same as the `host_` ports, for the loader.
- `reg_en`  out  1  register bus enable.
- `reg_rd`  out  1  read strobe, active-high.
- `reg_wr`  out  1  write strobe, active-high; the register latches on its falling edge.
- `reg_be`  out  2  byte enables to the register bus.
- `reg_addr`  out  ADDR_WIDTH  register address.
- `reg_wdata`  out  DATA_WIDTH  write data to the register bus.
- `reg_rdata`  in  DATA_WIDTH  read data from the register bus (combinational).

## Operation
- States: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- IDLE
  - If any request is eligible, grant one, latch its `wr`/`be`/`addr`/`wdata` into the bus registers, and go to SETUP.
  - A requester whose ack is high this cycle is not eligible.
- SETUP: `reg_en`=1, bus stable. For reads `reg_rd`=1; `reg_wr`=0.
- STROBE
  - Write: `reg_wr`=1.
  - Read: `reg_rd` stays 1; `reg_rdata` is captured into the granted port's `rdata` at the end of this cycle.
- HOLD: `reg_wr`=0 (falling edge commits the write), `reg_en`, address and data unchanged, `reg_rd`=0.
- Leaving HOLD: drop `reg_en`, pulse the granted port's ack for one cycle, return to IDLE.
- `rdata` holds its last value until the next read on that port. Writes leave `rdata` unchanged.
- Request fields are sampled only at grant; changes after grant have no effect.
- Arbitration (see Configuration): decided only in IDLE. An access in flight is never pre-empted.
- Simultaneous requests with one requester just acked: the other requester is granted.

## Timing
- Reset values: `reg_en`=`reg_rd`=`reg_wr`=0; `reg_be`, `reg_addr`, `reg_wdata`=0; both acks 0; both `rdata`=0; state IDLE; round-robin pointer = host-last (the loader wins the first tie).
- Reset mid-access: the access is aborted, no ack is issued, and all outputs take their reset values at that edge. The `Registers` block shares the reset, so register contents are reset-defined.
- Latency, request high in cycle C0 with the bus idle:
  - SETUP in C1, STROBE in C2, HOLD in C3.
  - Ack in C4, which is also IDLE; the earliest next grant is at the end of C4 and takes effect in C5 (SETUP).
- Throughput: one access per 4 cycles; back-to-back accesses from alternating requesters run at 4 cycles each.
- A requester must drop `req` in its ack cycle or issue a new access. Its `req` is ignored during the ack cycle.

## Configuration
- `REG_ARB_ROUND_ROBIN_EN` defined:
  - When both requesters are eligible, grant the one not granted last.
  - The pointer updates at each grant.
- `REG_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the host always wins ties.
  - The loader can starve; this is acceptable because host traffic is sparse.
  - No pointer register exists.

## Test plan
- Host write: `addr`=0x0010, `wdata`=0xBEEF, `be`=2'b11 -> `reg_en` high for C1–C3, `reg_wr` high only in C2, `host_ack` in C4; a read back of 0x0010 returns 0xBEEF.
- Loader read of 0x0012 while `reg_rdata`=0x1234 -> `reg_rd` high in C1–C2, `ldr_rdata`=0x1234 with `ldr_ack` in C4; `host_rdata` unchanged.
- Both requesting from reset (round-robin on) -> grant order loader, host, loader, host; each ack 4 cycles apart; with the macro off -> host granted each time it re-requests.
- Byte write, `be`=2'b01, `wdata`=0xAA55 -> `reg_be`=2'b01 throughout C1–C3; the register's high byte is unchanged.
- Reset asserted in STROBE -> next cycle all `reg_*`=0, no ack, state IDLE; a fresh request is granted normally after reset.
- Requester changes `addr` in C2 -> `reg_addr` keeps the value latched at grant.
